// File: rtl/game_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg: shared types and widths for the game sequencer.
//   state_e   - FSM state encoding (also driven out on the state port)
//   LEVEL_W   - width of the level counter
//   SCORE_W   - width of the score counter
//   LIVES_W   - width of the lives counter
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int LEVEL_W = 10;
    localparam int SCORE_W = 16;
    localparam int LIVES_W = 2;
    localparam int STATE_W = 3;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_PAUSED    = 3'd2,
        S_HIT       = 3'd3,
        S_LEVEL_UP  = 3'd4,
        S_GAME_OVER = 3'd5
    } state_e;

endpackage

// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if: player/environment events in, game status out.
//   start_i, pause_btn_i, bar_passed_i - one-cycle event pulses
//   collision_i                        - bird/bar overlap level
//   env_tick                           - one-cycle environment step enable
//   pause                              - freeze environment
//   level, score, lives, state         - registered game status
// master: the environment/player side; slave: the sequencer.
// ---------------------------------------------------------------------------
interface game_sequencer_if;
    import game_pkg::*;

    logic               start_i;
    logic               pause_btn_i;
    logic               collision_i;
    logic               bar_passed_i;
    logic               env_tick;
    logic               pause;
    logic [LEVEL_W-1:0] level;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic [STATE_W-1:0] state;

    modport master (
        output start_i, pause_btn_i, collision_i, bar_passed_i,
        input  env_tick, pause, level, score, lives, state
    );

    modport slave (
        input  start_i, pause_btn_i, collision_i, bar_passed_i,
        output env_tick, pause, level, score, lives, state
    );

endinterface

// File: rtl/game_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen: free-running 0..DIV-1 divider producing a registered one-cycle
// tick each time the count wraps.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset (clears count and tick)
//   tick  out one-cycle pulse, first one DIV edges after reset release
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 1666667
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // tick is registered off the terminal count, so it appears in the
    // cycle where the count has just wrapped back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer: top-level game flow control for a flappy-bird style game.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   bus   slave modport of game_sequencer_if (events in, status out)
// Holds the play FSM, level/score/lives counters, the per-level pass counter
// and the HIT/LEVEL_UP hold counter. The environment step enable comes from
// tick_gen, which runs in every state.
// ---------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV         = 1666667,
    parameter int PASSES_PER_LEVEL = 8,
    parameter int HOLD_TICKS       = 60,
    parameter int START_LIVES      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    game_sequencer_if.slave   bus
);

    localparam int PW = $clog2(PASSES_PER_LEVEL + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] PASS_TOP  = PW'(PASSES_PER_LEVEL);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic env_tick;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (env_tick)
    );

    state_e             state_q, state_d;
    logic               pause_q, pause_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [PW-1:0]      pass_q,  pass_d;
    logic [HW-1:0]      hold_q,  hold_d;
    logic [PW-1:0]      pass_inc;

    assign pass_inc = pass_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pause_q <= 1'b1;
            level_q <= '0;
            score_q <= '0;
            lives_q <= '0;
            pass_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            level_q <= level_d;
            score_q <= score_d;
            lives_q <= lives_d;
            pass_q  <= pass_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        score_d = score_q;
        lives_d = lives_q;
        pass_d  = pass_q;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (bus.start_i) begin
                    state_d = S_PLAY;
                    level_d = LEVEL_W'(1);
                    score_d = '0;
                    lives_d = LIVES_W'(START_LIVES);
                    pass_d  = '0;
                end
            end

            S_PLAY: begin
                // Collision wins outright: a bar cleared in the same cycle
                // does not score.
                if (bus.collision_i) begin
                    state_d = S_HIT;
                    lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
                    hold_d  = '0;
                end else if (bus.bar_passed_i) begin
                    score_d = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                    if (pass_inc == PASS_TOP) begin
                        pass_d  = '0;
                        level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 1'b1;
                        state_d = S_LEVEL_UP;
                        hold_d  = '0;
                    end else begin
                        pass_d  = pass_inc;
                    end
                end else if (bus.pause_btn_i) begin
                    state_d = S_PAUSED;
                end
            end

            S_PAUSED: begin
                if (bus.pause_btn_i) state_d = S_PLAY;
            end

            S_HIT, S_LEVEL_UP: begin
                // Hold for HOLD_TICKS environment steps; lives was already
                // decremented on HIT entry, so zero here means the last life.
                if (env_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = (state_q == S_HIT && lives_q == '0) ? S_GAME_OVER
                                                                       : S_PLAY;
                    end else begin
                        hold_d  = hold_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        pause_d = (state_d != S_PLAY);
    end

    assign bus.env_tick = env_tick;
    assign bus.pause    = pause_q;
    assign bus.level    = level_q;
    assign bus.score    = score_q;
    assign bus.lives    = lives_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer: directed bench for game_sequencer with a small divider
// (TICK_DIV=4, PASSES_PER_LEVEL=2, HOLD_TICKS=3, START_LIVES=3).
// Inputs are changed 1 time unit after a rising edge and outputs are sampled
// at the same point, so every step() reflects exactly one clock edge.
// ---------------------------------------------------------------------------
module tb_game_sequencer;
    import game_pkg::*;

    localparam int TD  = 4;
    localparam int PPL = 2;
    localparam int HT  = 3;
    localparam int SL  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    game_sequencer_if bus();

    game_sequencer #(
        .TICK_DIV         (TD),
        .PASSES_PER_LEVEL (PPL),
        .HOLD_TICKS       (HT),
        .START_LIVES      (SL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stay in state st until it is left (bounded), counting env_tick pulses
    // seen while still in st.
    task automatic wait_hold(input logic [2:0] st, output int ticks);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.state != st) break;
            if (bus.env_tick) ticks++;
            step();
        end
    endtask

    initial begin
        int tk;
        int n;
        bus.start_i      = 1'b0;
        bus.pause_btn_i  = 1'b0;
        bus.collision_i  = 1'b0;
        bus.bar_passed_i = 1'b0;

        // reset state
        repeat (3) step();
        check("rst_state", bus.state, 0);
        check("rst_pause", bus.pause, 1);
        check("rst_level", bus.level, 0);
        check("rst_score", bus.score, 0);
        check("rst_lives", bus.lives, 0);
        check("rst_tick",  bus.env_tick, 0);

        // divider phase after release: ticks on edges 4, 8, 12
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("tick_%0d", k), bus.env_tick, (k % 4 == 0) ? 1 : 0);
        end

        // start
        bus.start_i = 1'b1; step(); bus.start_i = 1'b0;
        check("start_state", bus.state, 1);
        check("start_pause", bus.pause, 0);
        check("start_level", bus.level, 1);
        check("start_lives", bus.lives, 3);
        check("start_score", bus.score, 0);

        // two bars -> level up
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("bar1_score", bus.score, 1);
        check("bar1_state", bus.state, 1);
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("bar2_score", bus.score, 2);
        check("bar2_level", bus.level, 2);
        check("bar2_state", bus.state, 4);
        check("bar2_pause", bus.pause, 1);

        // collision ignored in LEVEL_UP
        bus.collision_i = 1'b1; step(); bus.collision_i = 1'b0;
        check("lvup_coll_state", bus.state, 4);
        check("lvup_coll_lives", bus.lives, 3);
        wait_hold(3'd4, tk);
        check("lvup_ticks", tk, 3);
        check("lvup_exit",  bus.state, 1);
        check("lvup_pause", bus.pause, 0);

        // pass counter to 1, then collision+bar together
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("bar3_score", bus.score, 3);
        bus.collision_i = 1'b1; bus.bar_passed_i = 1'b1; step();
        bus.collision_i = 1'b0; bus.bar_passed_i = 1'b0;
        check("both_state", bus.state, 3);
        check("both_lives", bus.lives, 2);
        check("both_score", bus.score, 3);
        check("both_level", bus.level, 2);
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("hit_bar_score", bus.score, 3);
        check("hit_bar_state", bus.state, 3);
        wait_hold(3'd3, tk);
        check("hit1_ticks", tk, 3);
        check("hit1_exit",  bus.state, 1);

        // pass counter was left at 1, so one more bar levels up
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("bar4_score", bus.score, 4);
        check("bar4_level", bus.level, 3);
        check("bar4_state", bus.state, 4);
        wait_hold(3'd4, tk);
        check("lvup2_ticks", tk, 3);
        check("lvup2_exit",  bus.state, 1);

        // pause behaviour
        bus.pause_btn_i = 1'b1; step(); bus.pause_btn_i = 1'b0;
        check("pause_state", bus.state, 2);
        check("pause_pause", bus.pause, 1);
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("pause_bar_score", bus.score, 4);
        check("pause_bar_state", bus.state, 2);
        bus.collision_i = 1'b1; step(); bus.collision_i = 1'b0;
        check("pause_coll_state", bus.state, 2);
        check("pause_coll_lives", bus.lives, 2);
        bus.pause_btn_i = 1'b1; step(); bus.pause_btn_i = 1'b0;
        check("resume_state", bus.state, 1);
        check("resume_pause", bus.pause, 0);

        // bar beats pause button; start ignored in PLAY
        bus.bar_passed_i = 1'b1; bus.pause_btn_i = 1'b1; step();
        bus.bar_passed_i = 1'b0; bus.pause_btn_i = 1'b0;
        check("barpause_score", bus.score, 5);
        check("barpause_state", bus.state, 1);
        bus.start_i = 1'b1; step(); bus.start_i = 1'b0;
        check("play_start_state", bus.state, 1);
        check("play_start_level", bus.level, 3);
        check("play_start_score", bus.score, 5);

        // lose remaining lives
        bus.collision_i = 1'b1; step(); bus.collision_i = 1'b0;
        check("hit2_lives", bus.lives, 1);
        wait_hold(3'd3, tk);
        check("hit2_ticks", tk, 3);
        check("hit2_exit",  bus.state, 1);
        bus.collision_i = 1'b1; step(); bus.collision_i = 1'b0;
        check("hit3_lives", bus.lives, 0);
        check("hit3_state", bus.state, 3);
        wait_hold(3'd3, tk);
        check("hit3_ticks", tk, 3);
        check("over_state", bus.state, 5);
        check("over_pause", bus.pause, 1);
        bus.bar_passed_i = 1'b1; step(); bus.bar_passed_i = 1'b0;
        check("over_bar_score", bus.score, 5);
        bus.pause_btn_i = 1'b1; step(); bus.pause_btn_i = 1'b0;
        check("over_pbtn_state", bus.state, 5);
        bus.start_i = 1'b1; step(); bus.start_i = 1'b0;
        check("restart_state", bus.state, 1);
        check("restart_level", bus.level, 1);
        check("restart_score", bus.score, 0);
        check("restart_lives", bus.lives, 3);
        check("restart_pause", bus.pause, 0);

        // reset in the middle of a HIT hold
        bus.collision_i = 1'b1; step(); bus.collision_i = 1'b0;
        check("midhit_state", bus.state, 3);
        check("midhit_lives", bus.lives, 2);
        repeat (4) step();
        rst_n = 1'b0; step();
        check("midrst_state", bus.state, 0);
        check("midrst_lives", bus.lives, 0);
        check("midrst_level", bus.level, 0);
        check("midrst_score", bus.score, 0);
        check("midrst_pause", bus.pause, 1);
        check("midrst_tick",  bus.env_tick, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("midrst_tick_%0d", k), bus.env_tick, (k == 4) ? 1 : 0);
        end
        bus.start_i = 1'b1; step(); bus.start_i = 1'b0;
        check("post_rst_start", bus.state, 1);
        bus.collision_i = 1'b1; step(); bus.collision_i = 1'b0;
        check("post_rst_lives", bus.lives, 2);
        wait_hold(3'd3, tk);
        check("post_rst_ticks", tk, 3);
        check("post_rst_exit",  bus.state, 1);

        // climb to max level: 1022 level-ups at 2 bars each
        n = 0;
        for (int i = 0; i < 30000 && bus.level != 10'd1023; i++) begin
            bus.bar_passed_i = (bus.state == 3'd1);
            if (bus.bar_passed_i) n++;
            step();
        end
        bus.bar_passed_i = 1'b0;
        check("max_level", bus.level, 1023);
        check("max_score", bus.score, 2044);

        // 1000 more bars must not move the level
        n = 0;
        for (int i = 0; i < 20000 && n < 1000; i++) begin
            bus.bar_passed_i = (bus.state == 3'd1);
            if (bus.bar_passed_i) n++;
            step();
        end
        bus.bar_passed_i = 1'b0;
        step();
        check("sat_level", bus.level, 1023);
        check("sat_score", bus.score, 3044);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
